alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Two-requester arbiter and sequencer for the shared 32-bit MIPS ALU (ops ADD/SUB/SLL/NOR/AND/SLT).
- Requester 0 is the pipeline EX stage; requester 1 is the auxiliary address/branch unit.
- Grants one request per cycle, drives the ALU operand and control inputs, and registers the result into a single-entry response slot with valid/ready backpressure and a requester ID tag.

Parameters:
WIDTH, 32, operand/result width
SHW, 5, shift-amount width
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 always wins)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_opA, req0_opB  in  WIDTH  requester 0 operands
req0_shamt  in  SHW  requester 0 shift amount
req0_ctrl  in  3  requester 0 ALU op code
req1_valid / req1_ready / req1_opA / req1_opB / req1_shamt / req1_ctrl  same as requester 0
alu_opA, alu_opB  out  WIDTH  to ALU
alu_shamt  out  SHW  to ALU
alu_ctrl  out  3  to ALU
alu_out  in  WIDTH  ALU result
alu_carry  in  1  ALU carry (valid for ADD only)
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer takes the response
rsp_id  out  1  requester that owns the response
rsp_data  out  WIDTH  registered result
rsp_carry  out  1  registered carry
rsp_zero  out  1  registered zero flag
rsp_illegal  out  1  op code was 110 or 111

Behaviour:
- Reset (synchronous, reset high at a clk edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, rsp_zero=0, rsp_illegal=0.
  - last_grant=1, so requester 0 wins the first tie.
  - An in-flight response is discarded.
  - While reset is high, req*_ready=0 and no op is accepted.
- Slot free this cycle: slot_free = !rsp_valid | rsp_ready.
- Grant (combinational):
  - Only when slot_free.
  - Only one valid: that requester wins.
  - Both valid, RR_EN=1: winner is the requester other than last_grant. RR_EN=0: requester 0 wins.
  - reqN_ready = grantN. Transfer occurs on reqN_valid & reqN_ready.
- ALU drive:
  - On a grant, alu_* = the granted requester's fields.
  - With no grant, drive alu_ctrl=3'b111 (ALU_NOP) and alu_opA/alu_opB/alu_shamt = 0.
- Capture, on a clock edge with a grant:
  - rsp_valid<=1, rsp_id<=winner, rsp_data<=alu_out.
  - rsp_carry<=alu_carry if ctrl==ADD, else 0.
  - rsp_zero<=(alu_out==0), computed locally from alu_out.
  - rsp_illegal<=(ctrl==3'b110 | ctrl==3'b111). For illegal codes, rsp_data<=0, rsp_zero<=1, rsp_carry<=0.
  - last_grant<=winner, updated only on an actual grant.
- Drain: on rsp_valid & rsp_ready with no new grant, rsp_valid<=0. Data fields hold their old values.
- Latency and throughput:
  - Accepted in cycle N -> rsp_valid in N+1.
  - Back-to-back: one op per cycle while rsp_ready=1.
- Backpressure: rsp_valid=1 & rsp_ready=0 -> no grants, both ready=0, response fields stable.
- Requester rule: the requester holds all fields stable while valid & !ready. The arbiter does not check this.
- Simultaneous drain + grant: the new response replaces the old one in the same edge, with no bubble.
- Fairness: with both requesting continuously and rsp_ready=1 under RR, grants alternate 0,1,0,1. No requester waits more than 1 grant.
- Reset asserted mid-stream: all state is cleared on that edge. Ops presented during reset are not accepted and must be re-presented.

Decomposition:
- Shared package alu_pkg holds:
  - Op codes: ADD=000, SUB=001, SLL=010, NOR=011, AND=100, SLT=101, ALU_NOP=111.
  - WIDTH and SHW defaults.
  - An is_legal_op function.
- Sub-module rr_arb2: 2-way round-robin/fixed-priority grant.
  - Inputs: req[1:0], last_grant, enable, rr_en.
  - Output: one-hot gnt[1:0].
- The top level contains the operand mux, response register and last_grant register.

Test Plan:
- Reset then single op: req0 ADD opA=0xFFFFFFFF, opB=1 -> ready0=1 same cycle; next cycle rsp_valid=1, id=0, data=0, carry=1, zero=1, illegal=0.
- Contention, RR_EN=1, rsp_ready=1: both request SUB (req0: 5-5, req1: 9-3) for 4 cycles -> grants 0,1,0,1; rsp_data sequence 0,6,0,6; zero 1,0,1,0.
- Fixed priority, RR_EN=0: both valid for 3 cycles -> req1_ready=0 throughout; 3 responses with id=0.
- Backpressure: rsp_ready=0 after first response (SLT 3<7 -> data=1); hold 3 cycles -> ready0=ready1=0, rsp fields stable; raise rsp_ready -> next grant same cycle, new response the following cycle.
- Illegal op: req1 ctrl=3'b110 -> rsp_illegal=1, data=0, zero=1, carry=0, id=1. Idle cycle -> alu_ctrl=3'b111, operands 0.
- Reset mid-stream: assert reset while rsp_valid=1 and both requesting -> next cycle rsp_valid=0, ready=0 during reset; first post-reset tie granted to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the ALU op codes, the default operand/shift widths and a helper that
// tells legal op codes from the two reserved ones.
package alu_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_SHW   = 5;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_SLL = 3'b010,
      OP_NOR = 3'b011,
      OP_AND = 3'b100,
      OP_SLT = 3'b101,
      OP_RSV = 3'b110,
      OP_NOP = 3'b111
   } alu_op_e;

   // 110 is reserved and 111 is the idle/NOP code; neither is a real request
   function automatic logic is_legal_op(input logic [2:0] ctrl);
      return (ctrl <= 3'b101);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with optional round-robin.
// Ports:
//   req        - request vector, bit N = requester N
//   last_grant - requester that won the most recent grant
//   enable     - grants may be issued this cycle
//   rr_en      - 1 = round-robin on ties, 0 = requester 0 always wins
//   gnt        - one-hot grant (all zero when nothing is granted)
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       enable,
   input  logic       rr_en,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         if (req == 2'b11) begin
            // tie: hand the grant to whoever did not win last time
            gnt = (rr_en && !last_grant) ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter/sequencer for the shared 32-bit ALU.
// Requester 0 is the pipeline EX stage, requester 1 the auxiliary
// address/branch unit. One request is granted per cycle, its fields drive the
// ALU, and the result is captured into a single-entry response slot.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   reqN_valid/ready                 - request handshake, N = 0,1
//   reqN_opA/opB/shamt/ctrl          - request fields
//   alu_opA/opB/shamt/ctrl           - drive to the ALU (NOP and zeros when idle)
//   alu_out, alu_carry               - ALU result
//   rsp_valid/ready                  - response slot handshake
//   rsp_id/data/carry/zero/illegal   - registered response fields
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int SHW   = ALU_SHW,
   parameter int RR_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_opA,
   input  logic [WIDTH-1:0] req0_opB,
   input  logic [SHW-1:0]   req0_shamt,
   input  logic [2:0]       req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_opA,
   input  logic [WIDTH-1:0] req1_opB,
   input  logic [SHW-1:0]   req1_shamt,
   input  logic [2:0]       req1_ctrl,
   output logic [WIDTH-1:0] alu_opA,
   output logic [WIDTH-1:0] alu_opB,
   output logic [SHW-1:0]   alu_shamt,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             rsp_illegal
);

   logic       last_grant;
   logic       slot_free;
   logic [1:0] gnt;
   logic       granted;
   logic       winner;
   logic       op_legal;

   assign slot_free = !rsp_valid || rsp_ready;

   // reset gates the arbiter so nothing is accepted while it is held
   rr_arb2 u_arb (
      .req        ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .enable     (slot_free && !reset),
      .rr_en      (RR_EN != 0),
      .gnt        (gnt)
   );

   assign granted    = |gnt;
   assign winner     = gnt[1];
   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   always_comb begin
      alu_opA   = '0;
      alu_opB   = '0;
      alu_shamt = '0;
      alu_ctrl  = OP_NOP;
      if (granted) begin
         if (winner) begin
            alu_opA   = req1_opA;
            alu_opB   = req1_opB;
            alu_shamt = req1_shamt;
            alu_ctrl  = req1_ctrl;
         end else begin
            alu_opA   = req0_opA;
            alu_opB   = req0_opB;
            alu_shamt = req0_shamt;
            alu_ctrl  = req0_ctrl;
         end
      end
   end

   assign op_legal = is_legal_op(alu_ctrl);

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_data    <= '0;
         rsp_carry   <= 1'b0;
         rsp_zero    <= 1'b0;
         rsp_illegal <= 1'b0;
         last_grant  <= 1'b1;
      end else if (granted) begin
         // a grant always replaces the slot contents, even while it drains
         rsp_valid   <= 1'b1;
         rsp_id      <= winner;
         last_grant  <= winner;
         rsp_illegal <= !op_legal;
         if (op_legal) begin
            rsp_data  <= alu_out;
            rsp_zero  <= (alu_out == '0);
            rsp_carry <= (alu_ctrl == OP_ADD) ? alu_carry : 1'b0;
         end else begin
            rsp_data  <= '0;
            rsp_zero  <= 1'b1;
            rsp_carry <= 1'b0;
         end
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_opA, req0_opB, req1_opA, req1_opB;
   logic [4:0]  req0_shamt, req1_shamt;
   logic [2:0]  req0_ctrl, req1_ctrl;
   logic        rsp_ready;

   // round-robin instance
   logic        rr_ready0, rr_ready1;
   logic [31:0] rr_alu_opA, rr_alu_opB, rr_alu_out;
   logic [4:0]  rr_alu_shamt;
   logic [2:0]  rr_alu_ctrl;
   logic        rr_alu_carry;
   logic        rr_rsp_valid, rr_rsp_id, rr_rsp_carry, rr_rsp_zero, rr_rsp_illegal;
   logic [31:0] rr_rsp_data;

   // fixed-priority instance
   logic        fp_ready0, fp_ready1;
   logic [31:0] fp_alu_opA, fp_alu_opB, fp_alu_out;
   logic [4:0]  fp_alu_shamt;
   logic [2:0]  fp_alu_ctrl;
   logic        fp_alu_carry;
   logic        fp_rsp_valid, fp_rsp_id, fp_rsp_carry, fp_rsp_zero, fp_rsp_illegal;
   logic [31:0] fp_rsp_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Behavioural ALU. Carry is forced high for non-ADD ops and reserved codes
   // return opA, so the arbiter's masking of both is observable.
   function automatic logic [32:0] alu_model(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
      logic [32:0] r;
      case (c)
         3'b000:  r = {1'b0, a} + {1'b0, b};
         3'b001:  r = {1'b1, a - b};
         3'b010:  r = {1'b1, b << sh};
         3'b011:  r = {1'b1, ~(a | b)};
         3'b100:  r = {1'b1, a & b};
         3'b101:  r = {1'b1, 31'd0, ($signed(a) < $signed(b))};
         default: r = {1'b1, a};
      endcase
      return r;
   endfunction

   assign {rr_alu_carry, rr_alu_out} = alu_model(rr_alu_ctrl, rr_alu_opA, rr_alu_opB, rr_alu_shamt);
   assign {fp_alu_carry, fp_alu_out} = alu_model(fp_alu_ctrl, fp_alu_opA, fp_alu_opB, fp_alu_shamt);

   alu_arbiter #(.WIDTH(32), .SHW(5), .RR_EN(1)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(rr_ready0), .req0_opA(req0_opA), .req0_opB(req0_opB),
      .req0_shamt(req0_shamt), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(rr_ready1), .req1_opA(req1_opA), .req1_opB(req1_opB),
      .req1_shamt(req1_shamt), .req1_ctrl(req1_ctrl),
      .alu_opA(rr_alu_opA), .alu_opB(rr_alu_opB), .alu_shamt(rr_alu_shamt), .alu_ctrl(rr_alu_ctrl),
      .alu_out(rr_alu_out), .alu_carry(rr_alu_carry),
      .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id), .rsp_data(rr_rsp_data),
      .rsp_carry(rr_rsp_carry), .rsp_zero(rr_rsp_zero), .rsp_illegal(rr_rsp_illegal)
   );

   alu_arbiter #(.WIDTH(32), .SHW(5), .RR_EN(0)) u_fp (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(fp_ready0), .req0_opA(req0_opA), .req0_opB(req0_opB),
      .req0_shamt(req0_shamt), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(fp_ready1), .req1_opA(req1_opA), .req1_opB(req1_opB),
      .req1_shamt(req1_shamt), .req1_ctrl(req1_ctrl),
      .alu_opA(fp_alu_opA), .alu_opB(fp_alu_opB), .alu_shamt(fp_alu_shamt), .alu_ctrl(fp_alu_ctrl),
      .alu_out(fp_alu_out), .alu_carry(fp_alu_carry),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data),
      .rsp_carry(fp_rsp_carry), .rsp_zero(fp_rsp_zero), .rsp_illegal(fp_rsp_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
      req0_valid = v; req0_ctrl = c; req0_opA = a; req0_opB = b; req0_shamt = sh;
   endtask

   task automatic set_req1(input logic v, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
      req1_valid = v; req1_ctrl = c; req1_opA = a; req1_opB = b; req1_shamt = sh;
   endtask

   logic [3:0]  exp_id;
   logic [3:0]  exp_zero;
   logic [31:0] exp_data [4];

   initial begin
      reset     = 1'b1;
      rsp_ready = 1'b1;
      set_req0(1'b1, 3'b000, 32'h1, 32'h1, 5'd0);
      set_req1(1'b1, 3'b000, 32'h2, 32'h2, 5'd0);
      tick();
      tick();
      #1;
      chk("rst_ready0", rr_ready0, 0);
      chk("rst_ready1", rr_ready1, 0);
      chk("rst_rsp_valid", rr_rsp_valid, 0);
      chk("rst_rsp_data", rr_rsp_data, 0);
      chk("rst_rsp_flags", {rr_rsp_id, rr_rsp_carry, rr_rsp_zero, rr_rsp_illegal}, 0);

      // single ADD with carry out and zero result
      reset = 1'b0;
      set_req0(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1, 5'd0);
      set_req1(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      #1;
      chk("add_ready0", rr_ready0, 1);
      tick();
      chk("add_valid", rr_rsp_valid, 1);
      chk("add_id", rr_rsp_id, 0);
      chk("add_data", rr_rsp_data, 0);
      chk("add_carry", rr_rsp_carry, 1);
      chk("add_zero", rr_rsp_zero, 1);
      chk("add_illegal", rr_rsp_illegal, 0);
      req0_valid = 1'b0;
      tick();
      chk("drain_valid", rr_rsp_valid, 0);
      chk("drain_data_hold", rr_rsp_data, 0);

      // fresh reset so the round-robin pointer favours requester 0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_req0(1'b1, 3'b001, 32'd5, 32'd5, 5'd0);
      set_req1(1'b1, 3'b001, 32'd9, 32'd3, 5'd0);
      exp_id   = 4'b1010;
      exp_zero = 4'b0101;
      exp_data[0] = 32'd0; exp_data[1] = 32'd6; exp_data[2] = 32'd0; exp_data[3] = 32'd6;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rr_ready0_%0d", i), rr_ready0, !exp_id[i]);
         chk($sformatf("rr_ready1_%0d", i), rr_ready1, exp_id[i]);
         chk($sformatf("fp_ready1_%0d", i), fp_ready1, 0);
         tick();
         chk($sformatf("rr_id_%0d", i), rr_rsp_id, exp_id[i]);
         chk($sformatf("rr_data_%0d", i), rr_rsp_data, exp_data[i]);
         chk($sformatf("rr_zero_%0d", i), rr_rsp_zero, exp_zero[i]);
         chk($sformatf("rr_carry_%0d", i), rr_rsp_carry, 0);
         if (i < 3) begin
            chk($sformatf("fp_id_%0d", i), fp_rsp_id, 0);
            chk($sformatf("fp_data_%0d", i), fp_rsp_data, 0);
            chk($sformatf("fp_valid_%0d", i), fp_rsp_valid, 1);
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // backpressure: SLT response held while the consumer stalls
      set_req0(1'b1, 3'b101, 32'd3, 32'd7, 5'd0);
      tick();
      chk("slt_data", rr_rsp_data, 1);
      chk("slt_id", rr_rsp_id, 0);
      rsp_ready = 1'b0;
      set_req0(1'b1, 3'b000, 32'd2, 32'd3, 5'd0);
      set_req1(1'b1, 3'b100, 32'hF0, 32'h3C, 5'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp_ready0_%0d", i), rr_ready0, 0);
         chk($sformatf("bp_ready1_%0d", i), rr_ready1, 0);
         tick();
         chk($sformatf("bp_valid_%0d", i), rr_rsp_valid, 1);
         chk($sformatf("bp_data_%0d", i), rr_rsp_data, 1);
         chk($sformatf("bp_id_%0d", i), rr_rsp_id, 0);
      end
      // last grant went to 0, so the tie now goes to requester 1 (AND)
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready1", rr_ready1, 1);
      chk("bp_release_ready0", rr_ready0, 0);
      tick();
      chk("bp_new_data", rr_rsp_data, 32'h30);
      chk("bp_new_id", rr_rsp_id, 1);
      chk("bp_new_carry", rr_rsp_carry, 0);
      tick();
      chk("bp_add_data", rr_rsp_data, 32'd5);
      chk("bp_add_id", rr_rsp_id, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // reserved op code from requester 1
      set_req1(1'b1, 3'b110, 32'h1234, 32'h1, 5'd0);
      tick();
      chk("ill_flag", rr_rsp_illegal, 1);
      chk("ill_data", rr_rsp_data, 0);
      chk("ill_zero", rr_rsp_zero, 1);
      chk("ill_carry", rr_rsp_carry, 0);
      chk("ill_id", rr_rsp_id, 1);
      req1_valid = 1'b0;
      #1;
      chk("idle_ctrl", rr_alu_ctrl, 3'b111);
      chk("idle_opA", rr_alu_opA, 0);
      chk("idle_opB", rr_alu_opB, 0);
      chk("idle_shamt", rr_alu_shamt, 0);
      tick();

      // shift from requester 1
      set_req1(1'b1, 3'b010, 32'h0, 32'h3, 5'd4);
      #1;
      chk("sll_alu_shamt", rr_alu_shamt, 4);
      tick();
      chk("sll_data", rr_rsp_data, 32'h30);
      chk("sll_illegal", rr_rsp_illegal, 0);
      req1_valid = 1'b0;
      tick();

      // reset while busy; the pre-reset pointer would favour requester 1
      set_req0(1'b1, 3'b001, 32'd5, 32'd5, 5'd0);
      set_req1(1'b1, 3'b001, 32'd9, 32'd3, 5'd0);
      tick();
      chk("mid_pre_valid", rr_rsp_valid, 1);
      chk("mid_pre_id", rr_rsp_id, 0);
      reset = 1'b1;
      #1;
      chk("mid_rst_ready0", rr_ready0, 0);
      chk("mid_rst_ready1", rr_ready1, 0);
      tick();
      chk("mid_rst_valid", rr_rsp_valid, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready0", rr_ready0, 1);
      chk("post_rst_ready1", rr_ready1, 0);
      tick();
      chk("post_rst_id", rr_rsp_id, 0);
      chk("post_rst_valid", rr_rsp_valid, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
